regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 64, datapath width in bits.
REQ-002 Parameter RF_ADDR_WIDTH, default 5, register address width in bits.
REQ-003 Port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, reset; asynchronous and active-low.
REQ-005 Ports rf_raddr1 and rf_raddr2, input, RF_ADDR_WIDTH each, decode-stage read addresses.
REQ-006 Ports rf_rdata1 and rf_rdata2, output, XLEN each, read data.
REQ-007 Ports rs1_busy and rs2_busy, output, 1 bit each; the addressed register awaits a pending divide writeback.
REQ-008 Ports wb_req_rf, wb_waddr and wb_wdata, input, 1 / RF_ADDR_WIDTH / XLEN, writeback-stage write port.
REQ-009 Ports div_wr_valid, div_waddr and div_wdata, input, 1 / RF_ADDR_WIDTH / XLEN, divide-unit write request.
REQ-010 Port div_wr_ready, output, 1 bit, divide write accepted this cycle.
REQ-011 Ports iss_div and iss_rd, input, 1 / RF_ADDR_WIDTH; a divide with destination iss_rd issues this cycle.
REQ-012 Port flush, input, 1 bit, pipeline flush.

Function
REQ-013 The block SHALL hold 31 XLEN-bit registers x1..x31; x0 SHALL read zero and ignore all writes.
REQ-014 Reads SHALL be combinational: zero latency from rf_raddrN to rf_rdataN.
REQ-015 When wb_req_rf=1 and wb_waddr equals a nonzero read address, the matching rf_rdataN SHALL return wb_wdata in the same cycle (write-through bypass).
REQ-016 Otherwise, when a divide write is accepted to a nonzero address equal to the read address, rf_rdataN SHALL return div_wdata in the same cycle.
REQ-017 Where REQ-015 and REQ-016 both match, REQ-015 SHALL take priority.
REQ-018 div_wr_ready SHALL equal NOT (wb_req_rf AND wb_waddr!=0); the writeback port always wins arbitration.
REQ-019 A divide write SHALL commit on the clock edge where div_wr_valid=1 and div_wr_ready=1.
REQ-020 While div_wr_ready=0, the divide unit holds div_waddr and div_wdata stable; the block SHALL NOT drop the request.
REQ-021 The writeback write SHALL commit on the clock edge where wb_req_rf=1 and wb_waddr!=0.
REQ-022 The scoreboard SHALL keep one busy bit per register x1..x31.
REQ-023 An iss_div with iss_rd!=0 SHALL set busy[iss_rd] at the next edge.
REQ-024 An accepted divide write SHALL clear busy[div_waddr] at the next edge.
REQ-025 If a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-026 flush=1 SHALL clear all busy bits at the next edge and SHALL take priority over iss_div.
REQ-027 Register contents SHALL be unaffected by flush.
REQ-028 rsN_busy SHALL be combinational from the current busy bits.
REQ-029 rsN_busy SHALL be 0 for x0.
REQ-030 rsN_busy SHALL be 0 when an accepted divide write to that register occurs in the same cycle (bypass makes the data valid).
REQ-031 The busy bit of x0 SHALL never be set.

Reset
REQ-032 While rst_n=0, all registers SHALL be zero, all busy bits SHALL be zero, and rf_rdata1, rf_rdata2, rs1_busy and rs2_busy SHALL be zero.
REQ-033 Reset SHALL take effect immediately, independent of clk.
REQ-034 A divide write or iss_div coincident with reset assertion SHALL be discarded.
REQ-035 Writes SHALL resume on the first rising edge after rst_n deasserts.

Structure
REQ-036 XLEN, RF_ADDR_WIDTH, X0, ZEROWORD, TRUE and FALSE SHALL come from the shared defines file; no local redefinition.
REQ-037 The scoreboard SHALL be a sub-module named rf_scoreboard, containing the busy vector, set/clear/flush logic and the two busy lookups.
REQ-038 The storage array, arbitration and bypass SHALL reside in regfile_sb.

Verification
REQ-039 Write x5=0x1234 via WB, then read rf_raddr1=5 next cycle -> rf_rdata1=0x1234; a same-cycle read returns 0x1234 via bypass.
REQ-040 Write x0=0xFFFF via WB and via div -> rf_rdata1 reads 0 and div_wr_ready stays 1 when wb_waddr=0.
REQ-041 iss_div rd=7, then read rf_raddr2=7 -> rs2_busy=1; div write x7=0x55 accepted -> same cycle rs2_busy=0 and rf_rdata2=0x55; next cycle busy[7]=0.
REQ-042 wb_req_rf to x3 and div_wr_valid to x9 in the same cycle -> div_wr_ready=0 and x3 commits; next cycle div_wr_ready=1 and x9 commits.
REQ-043 Busy set on x4 and x6, then flush=1 together with iss_div rd=8 -> all busy bits 0 afterwards, x4 and x6 data unchanged.
REQ-044 Assert rst_n=0 mid-cycle after writes -> all reads return 0 and all busy outputs are 0 before the next clk edge.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file with divide scoreboard.
//   XLEN / RF_ADDR_WIDTH : default datapath and register-address widths
//   X0                   : address of the hardwired-zero register
//   ZEROWORD             : all-zero data word
//   TRUE / FALSE         : single-bit constants for flag updates
package regfile_sb_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned RF_ADDR_WIDTH = 5;

    localparam logic [RF_ADDR_WIDTH-1:0] X0       = '0;
    localparam logic [XLEN-1:0]          ZEROWORD = '0;
    localparam logic                     TRUE     = 1'b1;
    localparam logic                     FALSE    = 1'b0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for registers awaiting a divide writeback.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   set_i, set_addr_i        : divide issue; marks set_addr_i busy at the next edge
//   clr_i, clr_addr_i        : accepted divide write; clears clr_addr_i at the next edge
//   flush_i                  : clears every busy bit, overriding a same-cycle set
//   raddr1_i, raddr2_i       : lookup addresses
//   rs1_busy_o, rs2_busy_o   : lookup results (combinational)
module rf_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned AddrWidth = RF_ADDR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 set_i,
    input  logic [AddrWidth-1:0] set_addr_i,
    input  logic                 clr_i,
    input  logic [AddrWidth-1:0] clr_addr_i,
    input  logic                 flush_i,
    input  logic [AddrWidth-1:0] raddr1_i,
    input  logic [AddrWidth-1:0] raddr2_i,
    output logic                 rs1_busy_o,
    output logic                 rs2_busy_o
);

    localparam int unsigned NumRegs = 2 ** AddrWidth;

    logic [NumRegs-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            // Clear first so a same-register set in the same cycle wins.
            if (clr_i && clr_addr_i != X0) busy_d[clr_addr_i] = FALSE;
            if (set_i && set_addr_i != X0) busy_d[set_addr_i] = TRUE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A write landing this cycle is bypassed to the reader, so it is no longer busy.
    always_comb begin
        rs1_busy_o = (raddr1_i != X0) && busy_q[raddr1_i]
                     && !(clr_i && clr_addr_i == raddr1_i);
        rs2_busy_o = (raddr2_i != X0) && busy_q[raddr2_i]
                     && !(clr_i && clr_addr_i == raddr2_i);
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read register file (x0 hardwired to zero) with a writeback port, an arbitrated
// divide write port, write-through bypass and a divide busy scoreboard.
//   clk, rst_n                            : clock, asynchronous active-low reset
//   rf_raddr1/2 -> rf_rdata1/2            : combinational reads with bypass
//   rs1_busy, rs2_busy                    : addressed register awaits a divide result
//   wb_req_rf, wb_waddr, wb_wdata         : writeback write (always wins arbitration)
//   div_wr_valid, div_waddr, div_wdata    : divide write request
//   div_wr_ready                          : divide write accepted this cycle
//   iss_div, iss_rd                       : divide issue, marks iss_rd busy
//   flush                                 : clears the scoreboard only
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN          = regfile_sb_pkg::XLEN,
    parameter int unsigned RF_ADDR_WIDTH = regfile_sb_pkg::RF_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [RF_ADDR_WIDTH-1:0] rf_raddr1,
    input  logic [RF_ADDR_WIDTH-1:0] rf_raddr2,
    output logic [XLEN-1:0]          rf_rdata1,
    output logic [XLEN-1:0]          rf_rdata2,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    input  logic                     wb_req_rf,
    input  logic [RF_ADDR_WIDTH-1:0] wb_waddr,
    input  logic [XLEN-1:0]          wb_wdata,
    input  logic                     div_wr_valid,
    input  logic [RF_ADDR_WIDTH-1:0] div_waddr,
    input  logic [XLEN-1:0]          div_wdata,
    output logic                     div_wr_ready,
    input  logic                     iss_div,
    input  logic [RF_ADDR_WIDTH-1:0] iss_rd,
    input  logic                     flush
);

    localparam int unsigned NumRegs = 2 ** RF_ADDR_WIDTH;

    logic                     wb_we;
    logic                     div_acc;
    logic                     div_we;
    logic [XLEN-1:0]          regs_q [NumRegs];
    logic [RF_ADDR_WIDTH-1:0] raddr  [2];
    logic [XLEN-1:0]          rdata  [2];

    // Writes to x0 never occupy the port, so they never stall the divider.
    assign wb_we        = wb_req_rf && (wb_waddr != X0);
    assign div_wr_ready = !wb_we;
    assign div_acc      = div_wr_valid && div_wr_ready;
    assign div_we       = div_acc && (div_waddr != X0);

    // Entry 0 is reset and never written, so x0 always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else begin
            if (wb_we)  regs_q[wb_waddr]  <= wb_wdata;
            if (div_we) regs_q[div_waddr] <= div_wdata;
        end
    end

    assign raddr[0] = rf_raddr1;
    assign raddr[1] = rf_raddr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs_q[raddr[p]];
            if (wb_we && wb_waddr == raddr[p]) begin
                rdata[p] = wb_wdata;
            end else if (div_we && div_waddr == raddr[p]) begin
                rdata[p] = div_wdata;
            end
            // Bypass paths would otherwise leak live write data during reset.
            if (!rst_n) rdata[p] = ZEROWORD;
        end
    end

    assign rf_rdata1 = rdata[0];
    assign rf_rdata2 = rdata[1];

    rf_scoreboard #(
        .AddrWidth (RF_ADDR_WIDTH)
    ) u_scoreboard (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .set_i      (iss_div),
        .set_addr_i (iss_rd),
        .clr_i      (div_acc),
        .clr_addr_i (div_waddr),
        .flush_i    (flush),
        .raddr1_i   (rf_raddr1),
        .raddr2_i   (rf_raddr2),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reset checks, a directed vector table, randomized
// traffic against a behavioural model, and a mid-cycle asynchronous reset sequence.
module tb_regfile_sb;

    localparam int XL = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rf_raddr1, rf_raddr2;
    logic [XL-1:0] rf_rdata1, rf_rdata2;
    logic          rs1_busy, rs2_busy;
    logic          wb_req_rf;
    logic [AW-1:0] wb_waddr;
    logic [XL-1:0] wb_wdata;
    logic          div_wr_valid;
    logic [AW-1:0] div_waddr;
    logic [XL-1:0] div_wdata;
    logic          div_wr_ready;
    logic          iss_div;
    logic [AW-1:0] iss_rd;
    logic          flush;

    regfile_sb #(
        .XLEN          (XL),
        .RF_ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .wb_req_rf    (wb_req_rf),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .div_wr_valid (div_wr_valid),
        .div_waddr    (div_waddr),
        .div_wdata    (div_wdata),
        .div_wr_ready (div_wr_ready),
        .iss_div      (iss_div),
        .iss_rd       (iss_rd),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: architectural register values and the set of pending divides.
    logic [XL-1:0] m_mem  [32];
    bit            m_busy [32];

    typedef struct {
        logic          wb;  logic [AW-1:0] wa; logic [XL-1:0] wd;
        logic          dv;  logic [AW-1:0] da; logic [XL-1:0] dd;
        logic          iss; logic [AW-1:0] ir; logic          fl;
        logic [AW-1:0] a1;  logic [AW-1:0] a2;
        logic [XL-1:0] e1;  logic [XL-1:0] e2;
        logic          eb1; logic          eb2; logic          er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic wb, int wa, logic [XL-1:0] wd,
                                logic dv, int da, logic [XL-1:0] dd,
                                logic iss, int ir, logic fl, int a1, int a2,
                                logic [XL-1:0] e1, logic [XL-1:0] e2,
                                logic eb1, logic eb2, logic er);
        vec_t v;
        v.wb = wb;   v.wa = AW'(wa); v.wd = wd;
        v.dv = dv;   v.da = AW'(da); v.dd = dd;
        v.iss = iss; v.ir = AW'(ir); v.fl = fl;
        v.a1 = AW'(a1); v.a2 = AW'(a2);
        v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic set_idle();
        wb_req_rf = 0; wb_waddr = '0; wb_wdata = '0;
        div_wr_valid = 0; div_waddr = '0; div_wdata = '0;
        iss_div = 0; iss_rd = '0; flush = 0;
        rf_raddr1 = '0; rf_raddr2 = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 0;
        end
    endtask

    function automatic logic m_ready();
        return !(wb_req_rf && wb_waddr != 0);
    endfunction

    function automatic logic m_acc();
        return div_wr_valid && m_ready();
    endfunction

    function automatic logic [XL-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_req_rf && wb_waddr == a) return wb_wdata;
        if (m_acc() && div_waddr == a) return div_wdata;
        return m_mem[a];
    endfunction

    function automatic logic m_bsy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (m_acc() && div_waddr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".rdata1"}, rf_rdata1, m_read(rf_raddr1));
        chk({tag, ".rdata2"}, rf_rdata2, m_read(rf_raddr2));
        chk({tag, ".busy1"}, XL'(rs1_busy), XL'(m_bsy(rf_raddr1)));
        chk({tag, ".busy2"}, XL'(rs2_busy), XL'(m_bsy(rf_raddr2)));
        chk({tag, ".ready"}, XL'(div_wr_ready), XL'(m_ready()));
    endtask

    // Advance the model with the inputs present before the edge, then cross the edge.
    task automatic tick();
        if (wb_req_rf && wb_waddr != 0) m_mem[wb_waddr] = wb_wdata;
        if (m_acc() && div_waddr != 0) m_mem[div_waddr] = div_wdata;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            if (m_acc() && div_waddr != 0) m_busy[div_waddr] = 0;
            if (iss_div && iss_rd != 0) m_busy[iss_rd] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, 31));
    endfunction

    initial begin
        bit hold;
        model_reset();
        set_idle();

        // Activity during reset must be invisible and must not commit.
        wb_req_rf = 1; wb_waddr = 5; wb_wdata = 64'h1234;
        div_wr_valid = 1; div_waddr = 6; div_wdata = 64'h66;
        iss_div = 1; iss_rd = 7;
        rf_raddr1 = 5; rf_raddr2 = 6;
        #2;
        chk("rst.rdata1", rf_rdata1, '0);
        chk("rst.rdata2", rf_rdata2, '0);
        chk("rst.busy1", XL'(rs1_busy), '0);
        chk("rst.busy2", XL'(rs2_busy), '0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        set_idle();
        rst_n = 1;
        rf_raddr1 = 5; rf_raddr2 = 7;
        #1;
        chk("post_rst.x5", rf_rdata1, '0);
        chk("post_rst.busy7", XL'(rs2_busy), '0);
        @(posedge clk);
        #1;

        //        wb  wa  wd        dv  da  dd        iss ir fl a1  a2  e1        e2        b1 b2 rdy
        tbl.push_back(mk(1, 5, 64'h1234, 0, 0, 64'h0,    0, 0, 0, 5,  0,  64'h1234, 64'h0,    0, 0, 0));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 5,  5,  64'h1234, 64'h1234, 0, 0, 1));
        tbl.push_back(mk(1, 0, 64'hFFFF, 1, 0, 64'hFFFF, 0, 0, 0, 0,  5,  64'h0,    64'h1234, 0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 0,  5,  64'h0,    64'h1234, 0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    1, 7, 0, 5,  7,  64'h1234, 64'h0,    0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 7,  7,  64'h0,    64'h0,    1, 1, 1));
        tbl.push_back(mk(0, 0, 64'h0,    1, 7, 64'h55,   0, 0, 0, 7,  7,  64'h55,   64'h55,   0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 7,  7,  64'h55,   64'h55,   0, 0, 1));
        tbl.push_back(mk(1, 3, 64'hAAAA, 1, 9, 64'h9999, 0, 0, 0, 3,  9,  64'hAAAA, 64'h0,    0, 0, 0));
        tbl.push_back(mk(0, 0, 64'h0,    1, 9, 64'h9999, 0, 0, 0, 3,  9,  64'hAAAA, 64'h9999, 0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 9,  3,  64'h9999, 64'hAAAA, 0, 0, 1));
        tbl.push_back(mk(1, 4, 64'h4444, 0, 0, 64'h0,    1, 4, 0, 4,  0,  64'h4444, 64'h0,    0, 0, 0));
        tbl.push_back(mk(1, 6, 64'h6666, 0, 0, 64'h0,    1, 6, 0, 4,  6,  64'h4444, 64'h6666, 1, 0, 0));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    1, 8, 1, 4,  6,  64'h4444, 64'h6666, 1, 1, 1));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 4,  8,  64'h4444, 64'h0,    0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 6,  8,  64'h6666, 64'h0,    0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    1, 10, 0, 10, 0, 64'h0,    64'h0,    0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0,    1, 10, 64'hA0,  1, 10, 0, 10, 0, 64'hA0,   64'h0,    0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 10, 0,  64'hA0,   64'h0,    1, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0,    1, 10, 64'hB0,  0, 0, 0, 10, 0,  64'hB0,   64'h0,    0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 10, 0,  64'hB0,   64'h0,    0, 0, 1));

        foreach (tbl[k]) begin
            string t;
            t = $sformatf("vec%0d", k);
            wb_req_rf = tbl[k].wb;     wb_waddr = tbl[k].wa;  wb_wdata = tbl[k].wd;
            div_wr_valid = tbl[k].dv;  div_waddr = tbl[k].da; div_wdata = tbl[k].dd;
            iss_div = tbl[k].iss;      iss_rd = tbl[k].ir;    flush = tbl[k].fl;
            rf_raddr1 = tbl[k].a1;     rf_raddr2 = tbl[k].a2;
            #3;
            chk({t, ".rdata1"}, rf_rdata1, tbl[k].e1);
            chk({t, ".rdata2"}, rf_rdata2, tbl[k].e2);
            chk({t, ".busy1"}, XL'(rs1_busy), XL'(tbl[k].eb1));
            chk({t, ".busy2"}, XL'(rs2_busy), XL'(tbl[k].eb2));
            chk({t, ".ready"}, XL'(div_wr_ready), XL'(tbl[k].er));
            tick();
        end

        // Randomized traffic; a refused divide write is held until accepted.
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            wb_req_rf = ($urandom_range(0, 2) == 0);
            wb_waddr  = rnd_addr();
            wb_wdata  = {$urandom, $urandom};
            if (!hold) begin
                div_wr_valid = ($urandom_range(0, 2) == 0);
                div_waddr    = rnd_addr();
                div_wdata    = {$urandom, $urandom};
            end
            iss_div   = ($urandom_range(0, 2) == 0);
            iss_rd    = rnd_addr();
            flush     = ($urandom_range(0, 19) == 0);
            rf_raddr1 = rnd_addr();
            rf_raddr2 = rnd_addr();
            #3;
            check_model($sformatf("rnd%0d", c));
            hold = div_wr_valid && !m_ready();
            tick();
        end

        // Asynchronous reset asserted mid-cycle, with a bypass and a busy register live.
        set_idle();
        iss_div = 1; iss_rd = 12;
        tick();
        set_idle();
        wb_req_rf = 1; wb_waddr = 13; wb_wdata = 64'hDEAD_BEEF;
        rf_raddr1 = 13; rf_raddr2 = 12;
        #1;
        check_model("pre_arst");
        rst_n = 0;
        #1;
        chk("arst.rdata1", rf_rdata1, '0);
        chk("arst.rdata2", rf_rdata2, '0);
        chk("arst.busy1", XL'(rs1_busy), '0);
        chk("arst.busy2", XL'(rs2_busy), '0);
        model_reset();
        @(negedge clk);
        set_idle();
        rst_n = 1;
        @(posedge clk);
        #1;
        wb_req_rf = 1; wb_waddr = 5; wb_wdata = 64'h77;
        tick();
        set_idle();
        rf_raddr1 = 5; rf_raddr2 = 12;
        #1;
        chk("resume.x5", rf_rdata1, 64'h77);
        chk("resume.busy12", XL'(rs2_busy), '0);
        rf_raddr2 = 13;
        #1;
        chk("resume.x13", rf_rdata2, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
